sequence_tx_serializer: RTL and testbench
=========================================

// Module: sequence_tx_serializer
// PURPOSE
//  Parallel-to-serial bit-stream transmitter: the source end of the single-bit sequence_in
//  link consumed by Sequence_Detector_MOORE. Accepts a WIDTH-bit word via valid/ready,
//  shifts it out one bit per clock on sequence_out, then idles low for a programmable gap.
//  Drives detector benches and on-chip pattern sources.
// PARAMETERS
//  WIDTH       8  bits per frame; legal range >= 2
//  GAP_CYCLES  1  low cycles after each frame before data_ready re-asserts; legal range >= 0
//  MSB_FIRST   1  1: data_in[WIDTH-1] sent first; 0: data_in[0] sent first
// PORTS
//  clock         in   1      rising-edge clock
//  reset         in   1      synchronous, active-high reset
//  data_in       in   WIDTH  word to serialize; sampled only on handshake
//  data_valid    in   1      word available
//  data_ready    out  1      high only in IDLE; handshake = data_valid & data_ready at posedge
//  sequence_out  out  1      serial bit, registered (Moore); 0 when not shifting
//  busy          out  1      high in SHIFT/PAR/GAP
//  frame_done    out  1      1-cycle pulse coincident with last bit of frame on sequence_out
// BEHAVIOUR
//  - Reset (sync, priority over all): state=IDLE, sequence_out=0, data_ready=1, busy=0,
//    frame_done=0, shift reg/counters cleared. Mid-frame reset drops the frame; no frame_done.
//  - FSM states: IDLE, SHIFT, PAR (macro only), GAP. All outputs decode from registers only.
//  - IDLE: data_ready=1, sequence_out=0. Handshake -> capture data_in, bit_cnt=0, go SHIFT.
//  - Latency: first bit visible on sequence_out in the cycle after the handshake edge.
//  - SHIFT: one bit per cycle, WIDTH cycles; bit_cnt counts 0..WIDTH-1, no wrap beyond.
//    At bit_cnt==WIDTH-1: -> PAR if macro, else GAP if GAP_CYCLES>0, else IDLE.
//  - GAP: sequence_out=0, data_ready=0 for exactly GAP_CYCLES cycles, then IDLE.
//  - data_valid outside IDLE is ignored; data_in changes mid-frame have no effect.
//  - Minimum frame period = 1 + WIDTH (+1 parity) + GAP_CYCLES clocks.
//  - frame_done is never asserted in IDLE or GAP; it is never asserted twice per frame.
// CONFIGURATION
//  SEQ_TX_PARITY_EN defined: after the last data bit, state PAR emits one even-parity bit
//    (XOR of all WIDTH captured bits); frame_done moves to the PAR cycle; frame grows by 1.
//  SEQ_TX_PARITY_EN undefined: no PAR state, no parity logic; frame is exactly WIDTH bits.
// STRUCTURE
//  - Shared package/include seq_pkg: state encodings (IDLE/SHIFT/PAR/GAP), shared with the
//    detector benches; width helper for counter sizing ($clog2 of WIDTH and GAP_CYCLES+1).
//  - Sub-module seq_tx_shift_reg: loadable WIDTH-bit shift register, MSB_FIRST-selectable
//    direction, exposes current serial bit and captured-word parity.
//  - Top: FSM, bit counter, gap counter, output registers.
// TESTING
//  1 WIDTH=8, MSB_FIRST=1, send 8'hB4 -> sequence_out 1,0,1,1,0,1,0,0 on cycles 1..8 after
//    handshake; frame_done only on cycle 8; data_ready re-asserts after GAP_CYCLES=1 low cycle.
//  2 MSB_FIRST=0, send 8'hB4 -> bits 0,0,1,0,1,1,0,1; same timing as scenario 1.
//  3 data_valid held high, words 8'hFF,8'h00 back-to-back, GAP_CYCLES=0 -> 8 ones, 1 idle
//    zero, 8 zeros; exactly 2 frame_done pulses, 1 IDLE cycle between frames.
//  4 Reset asserted at 4th bit of 8'hFF -> next cycle sequence_out=0, data_ready=1, busy=0,
//    no frame_done; following word transmits cleanly.
//  5 SEQ_TX_PARITY_EN, send 8'hB4 (four 1s) -> 8 data bits then parity 0; 8'hB5 -> parity 1;
//    frame_done on parity cycle.
//  6 Loopback into Sequence_Detector_MOORE, send 8'hB4 then 8'h00 -> detector_out asserts
//    exactly once per target-pattern occurrence; busy/data_ready never both high.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the single-bit sequence link: FSM state encodings used by the
// transmitter and detector benches, plus a counter-width helper.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_GAP   = 2'd3
  } seq_state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_tx_shift_reg.sv
// Loadable WIDTH-bit shift register for the sequence transmitter. It exposes the bit that
// will be on the wire after the coming edge, and (with SEQ_TX_PARITY_EN) the even parity
// of the captured word.
module seq_tx_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
`ifdef SEQ_TX_PARITY_EN
  output logic             parity_next,
`endif
  output logic             next_bit
);

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    word_d = word_q;
    if (load) begin
      word_d = data_in;
    end else if (shift) begin
      word_d = MSB_FIRST ? {word_q[WIDTH-2:0], 1'b0} : {1'b0, word_q[WIDTH-1:1]};
    end
    next_bit = MSB_FIRST ? word_d[WIDTH-1] : word_d[0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

`ifdef SEQ_TX_PARITY_EN
  logic parity_q;

  // Parity is taken from the captured word, so later data_in changes cannot disturb it.
  always_comb begin
    parity_next = load ? ^data_in : parity_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_next;
    end
  end
`endif

endmodule

// File: rtl/sequence_tx_serializer.sv
// Parallel-to-serial transmitter for the sequence_in link: valid/ready word in, one bit per
// clock out, then a programmable low gap. Optional even-parity bit via SEQ_TX_PARITY_EN.
module sequence_tx_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             sequence_out,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = cnt_width(WIDTH);
  localparam int GW = cnt_width(GAP_CYCLES + 1);

  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [BW-1:0] PRE_LAST = BW'(WIDTH - 2);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam seq_state_e AFTER_FRAME = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
`ifdef SEQ_TX_PARITY_EN
  localparam seq_state_e AFTER_DATA = ST_PAR;
`else
  localparam seq_state_e AFTER_DATA = AFTER_FRAME;
`endif

  seq_state_e    state_q, state_d;
  logic [BW-1:0] bit_cnt_q;
  logic [GW-1:0] gap_cnt_q;
  logic          load, shift;
  logic          sr_next_bit;
  logic          seq_d, done_d;
`ifdef SEQ_TX_PARITY_EN
  logic          sr_parity_next;
`endif

  seq_tx_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .shift       (shift),
    .data_in     (data_in),
`ifdef SEQ_TX_PARITY_EN
    .parity_next (sr_parity_next),
`endif
    .next_bit    (sr_next_bit)
  );

  // data_ready is high exactly in IDLE, so a valid seen in IDLE is the handshake.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_valid) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift = 1'b1;
        if (bit_cnt_q == LAST_BIT) state_d = AFTER_DATA;
      end
      ST_PAR:  state_d = AFTER_FRAME;
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the wire sees them the cycle after the edge.
  always_comb begin
    seq_d = 1'b0;
    case (state_d)
      ST_SHIFT: seq_d = sr_next_bit;
`ifdef SEQ_TX_PARITY_EN
      ST_PAR:   seq_d = sr_parity_next;
`endif
      default:  seq_d = 1'b0;
    endcase
`ifdef SEQ_TX_PARITY_EN
    done_d = (state_d == ST_PAR);
`else
    done_d = (state_q == ST_SHIFT) && (bit_cnt_q == PRE_LAST);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      sequence_out <= 1'b0;
      data_ready   <= 1'b1;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (load) begin
        bit_cnt_q <= '0;
      end else if (state_q == ST_SHIFT && bit_cnt_q != LAST_BIT) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end

      if (state_q == ST_GAP && state_d == ST_GAP) begin
        gap_cnt_q <= gap_cnt_q + 1'b1;
      end else begin
        gap_cnt_q <= '0;
      end

      sequence_out <= seq_d;
      data_ready   <= (state_d == ST_IDLE);
      busy         <= (state_d != ST_IDLE);
      frame_done   <= done_d;
    end
  end

endmodule

// File: tb/tb_sequence_tx_serializer.sv
// Randomized self-checking bench for sequence_tx_serializer: two instances (MSB-first with
// a 1-cycle gap, LSB-first with no gap) compared cycle by cycle against a frame-level model.
module tb_sequence_tx_serializer;

  localparam int WIDTH  = 8;
  localparam int CYCLES = 3000;
`ifdef SEQ_TX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             ready_o [2];
  logic             seq_o   [2];
  logic             busy_o  [2];
  logic             done_o  [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state per lane: position in the current frame (-1 = none) and gap cycles left.
  int               cur_pos  [2];
  int               gap_left [2];
  logic [WIDTH-1:0] frame    [2];

  always #5 clock = ~clock;

  sequence_tx_serializer #(.WIDTH(WIDTH), .GAP_CYCLES(1), .MSB_FIRST(1'b1)) u_dut_msb (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (ready_o[0]),
    .sequence_out (seq_o[0]),
    .busy         (busy_o[0]),
    .frame_done   (done_o[0])
  );

  sequence_tx_serializer #(.WIDTH(WIDTH), .GAP_CYCLES(0), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (ready_o[1]),
    .sequence_out (seq_o[1]),
    .busy         (busy_o[1]),
    .frame_done   (done_o[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int lane_gap(input int lane);
    return (lane == 0) ? 1 : 0;
  endfunction

  function automatic logic exp_bit(input int lane);
    int pos;
    pos = cur_pos[lane];
    if (pos >= WIDTH) return ^frame[lane];
    return (lane == 0) ? frame[lane][WIDTH-1-pos] : frame[lane][pos];
  endfunction

  // Advance the model across one rising edge using the inputs stable at that edge.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        cur_pos[i]  = -1;
        gap_left[i] = 0;
      end else if (cur_pos[i] >= 0) begin
        if (cur_pos[i] == FRAME_LEN - 1) begin
          cur_pos[i]  = -1;
          gap_left[i] = lane_gap(i);
        end else begin
          cur_pos[i]++;
        end
      end else if (gap_left[i] > 0) begin
        gap_left[i]--;
      end else if (data_valid) begin
        frame[i]   = data_in;
        cur_pos[i] = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    logic e_seq, e_done, e_busy, e_ready;
    for (int i = 0; i < 2; i++) begin
      e_seq   = 1'b0;
      e_done  = 1'b0;
      e_busy  = 1'b1;
      e_ready = 1'b0;
      if (cur_pos[i] >= 0) begin
        e_seq  = exp_bit(i);
        e_done = (cur_pos[i] == FRAME_LEN - 1);
      end else if (gap_left[i] == 0) begin
        e_busy  = 1'b0;
        e_ready = 1'b1;
      end
      check($sformatf("lane%0d_sequence_out", i), 32'(seq_o[i]),   32'(e_seq));
      check($sformatf("lane%0d_frame_done", i),   32'(done_o[i]),  32'(e_done));
      check($sformatf("lane%0d_busy", i),         32'(busy_o[i]),  32'(e_busy));
      check($sformatf("lane%0d_data_ready", i),   32'(ready_o[i]), 32'(e_ready));
    end
  endtask

  // Directed prologue (0xB4 frame, 0xFF/0x00 back-to-back, mid-frame reset), then random.
  task automatic drive_inputs(input int c);
    reset      = 1'b0;
    data_valid = 1'b0;
    if (c == 0) begin
      data_valid = 1'b1;
      data_in    = 8'hB4;
    end else if (c >= 12 && c <= 40) begin
      data_valid = 1'b1;
      data_in    = (c == 12) ? 8'hFF : 8'h00;
    end else if (c == 45) begin
      data_valid = 1'b1;
      data_in    = 8'hFF;
    end else if (c == 49) begin
      reset = 1'b1;
    end else if (c == 51) begin
      data_valid = 1'b1;
      data_in    = 8'h5A;
    end else if (c >= 70) begin
      data_valid = ($urandom_range(0, 2) != 0);
      data_in    = WIDTH'($urandom);
      reset      = ($urandom_range(0, 99) == 0);
    end else begin
      data_in = WIDTH'($urandom);
    end
  endtask

  initial begin
    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    @(posedge clock);
    model_step();
    for (int c = 0; c < CYCLES; c++) begin
      @(negedge clock);
      cyc = c;
      compare_outputs();
      drive_inputs(c);
      @(posedge clock);
      model_step();
    end
    @(negedge clock);
    cyc = CYCLES;
    compare_outputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
